uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Debug/boot bus initiator on the CPU memory bus, driven by byte commands from the UART core.
- Receives command frames over UART, performs one 32-bit read or write as a mem_valid/mem_ready initiator, and sends a response back over UART.
- Lets a host load BRAM/SDRAM and poke peripherals while the CPU is held in reset.
- Sits between the UART core (received/rx_byte/transmit/tx_byte/is_transmitting) and the address decode/mux, in the initiator slot normally taken by the CPU.

Parameters:
FRAME_TIMEOUT, 2500000, max clk cycles between two bytes of one frame before the frame is discarded (100 ms at 25 MHz).
BUS_TIMEOUT, 1024, max clk cycles mem_valid may wait for mem_ready before the access is aborted.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_received  in  1  one-cycle strobe, rx_byte valid (UART core "received")
rx_byte  in  8  received byte
rx_error  in  1  UART receive error strobe
tx_trigger  out  1  one-cycle strobe to start sending tx_byte
tx_byte  out  8  byte to send, stable from tx_trigger until is_transmitting falls
tx_busy  in  1  UART core is_transmitting
mem_valid  out  1  bus request
mem_instr  out  1  constant 0
mem_ready  in  1  responder ready
mem_addr  out  32  word address, bits [1:0] forced 00
mem_wdata  out  32  write data
mem_wstrb  out  4  4'b1111 for write, 4'b0000 for read
mem_rdata  in  32  read data, valid in the mem_ready cycle
busy  out  1  high in every state except IDLE
overrun  out  1  sticky: a byte arrived while not accepting; cleared only by rst

Behaviour:
- Reset (rst sampled high at posedge): state IDLE; tx_trigger=0, tx_byte=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, overrun=0, all counters 0. Applies mid-frame, mid-bus-access and mid-transmit: mem_valid drops on the next edge, and any partial frame or response is discarded.
- Frame format, all fields big-endian:
  - 'W' (0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> write; response 0x4B ('K').
  - 'R' (0x52) A3 A2 A1 A0 -> read; response rdata bytes, MSB first.
  - Any other opcode byte in IDLE -> response 0x3F ('?'), no bus access.
- States: IDLE, GET_ADDR, GET_DATA, BUS, TX_START, TX_GUARD, TX_WAIT.
- IDLE: on rx_received, latch the opcode. 'W' or 'R' -> GET_ADDR with byte count 0. Otherwise load a 1-byte response of 0x3F -> TX_START.
- GET_ADDR: each rx_received shifts the byte into addr (addr <= {addr[23:0], byte}). On the 4th byte, 'R' -> BUS and 'W' -> GET_DATA.
- GET_DATA: same shifting into wdata. On the 4th byte -> BUS.
- Frame timeout counter: reset on every accepted byte; increments in GET_ADDR and GET_DATA. On reaching FRAME_TIMEOUT -> IDLE, no response.
- rx_error in GET_ADDR or GET_DATA -> IDLE, no response. rx_error in other states is ignored.
- BUS:
  - mem_valid=1 on the first BUS cycle (registered), with addr, wdata and wstrb stable while valid is high.
  - mem_ready sampled high in a cycle with mem_valid=1 completes the access. A zero-wait-state responder (mem_ready already high) completes in the first valid cycle.
  - On completion: mem_valid=0 on the next edge; capture mem_rdata for a read; load the response ('K', or 4 rdata bytes) -> TX_START.
  - Bus counter increments each cycle mem_valid=1 and mem_ready=0. On reaching BUS_TIMEOUT: drop mem_valid, response 0x45 ('E') -> TX_START.
  - mem_valid is never reasserted for the same frame.
- Response buffer: 32-bit shift register plus remaining-byte count (1..4); tx_byte = buffer[31:24].
- TX_START: wait for tx_busy=0, then pulse tx_trigger for exactly one cycle -> TX_GUARD.
- TX_GUARD: one cycle that ignores tx_busy, covering the core's one-cycle rise latency -> TX_WAIT.
- TX_WAIT: on tx_busy=0, decrement the count and shift the buffer left 8. If the count reaches 0 -> IDLE, else -> TX_START.
- rx_received in BUS, TX_START, TX_GUARD or TX_WAIT: byte dropped, overrun<=1. rx_received and a state change in the same cycle: the state being left decides.
- Opcode or response bytes never reach the bus; mem_wstrb is only ever 1111 or 0000.

Test Plan:
- Write: send 57 40 00 00 10 DE AD BE EF; responder ready after 3 cycles -> one access at addr 0x40000010, wdata 0xDEADBEEF, wstrb 1111, mem_valid high exactly 4 cycles; UART sends 0x4B; busy returns to 0.
- Read, zero-wait: send 52 00 00 00 07 with mem_ready tied 1 and mem_rdata=0x12345678 -> mem_addr 0x00000004, wstrb 0000, mem_valid high 1 cycle; UART sends 12 34 56 78 in order, each tx_trigger one cycle wide and issued only after tx_busy falls.
- Unknown opcode 0x41 -> UART sends 0x3F, no mem_valid. A following 'R' frame is handled normally.
- Frame timeout (FRAME_TIMEOUT=100): send 57 00 00, then idle 100 cycles -> state IDLE, no response, no bus access. A later complete frame works.
- Bus timeout (BUS_TIMEOUT=16, mem_ready held 0): read frame -> mem_valid high exactly 16 cycles then low; UART sends 0x45.
- Overrun and reset: send an extra byte during the response transmit -> overrun=1, response unaffected. Assert rst with mem_valid high -> mem_valid=0 and busy=0 on the next edge, overrun=0.

Source files
------------

// File: rtl/uart_bus_master.sv
// UART-driven debug bus initiator: 'W'/'R' command frames in,
// one 32-bit mem_valid/mem_ready access, response bytes out.
module uart_bus_master #(
  parameter int unsigned FRAME_TIMEOUT = 2500000,
  parameter int unsigned BUS_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_received,
  input  logic [7:0]  rx_byte,
  input  logic        rx_error,
  output logic        tx_trigger,
  output logic [7:0]  tx_byte,
  input  logic        tx_busy,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);

  localparam logic [31:0] FT = FRAME_TIMEOUT;
  localparam logic [31:0] BT = BUS_TIMEOUT;

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;
  localparam logic [7:0] RSP_E = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_TXS,
    S_TXG,
    S_TXW
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] rsp_q, rsp_d;
  logic [2:0]  rn_q, rn_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
      bcnt_q  <= '0;
      rsp_q   <= '0;
      rn_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      bcnt_q  <= bcnt_d;
      rsp_q   <= rsp_d;
      rn_q    <= rn_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tmo_d      = tmo_q;
    bcnt_d     = bcnt_q;
    rsp_d      = rsp_q;
    rn_d       = rn_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    tx_trigger = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_received) begin
          cnt_d = '0;
          if (rx_byte == OP_W || rx_byte == OP_R) begin
            wr_d    = (rx_byte == OP_W);
            state_d = S_ADDR;
          end else begin
            rsp_d   = {RSP_Q, 24'h0};
            rn_d    = 3'd1;
            state_d = S_TXS;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_error) begin
          state_d = S_IDLE;
        end else if (rx_received) begin
          tmo_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == S_ADDR) addr_d  = {addr_q[23:0], rx_byte};
          else                   wdata_d = {wdata_q[23:0], rx_byte};
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              valid_d = 1'b1;
              bcnt_d  = '0;
            end
          end
        end else if (tmo_q + 32'd1 == FT) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_BUS: begin
        if (valid_q) begin
          if (mem_ready) begin
            valid_d = 1'b0;
            state_d = S_TXS;
            if (wr_q) begin
              rsp_d = {RSP_K, 24'h0};
              rn_d  = 3'd1;
            end else begin
              rsp_d = mem_rdata;
              rn_d  = 3'd4;
            end
          end else if (bcnt_q + 32'd1 == BT) begin
            valid_d = 1'b0;
            rsp_d   = {RSP_E, 24'h0};
            rn_d    = 3'd1;
            state_d = S_TXS;
          end else begin
            bcnt_d = bcnt_q + 32'd1;
          end
        end
      end
      S_TXS: begin
        if (!tx_busy) begin
          tx_trigger = 1'b1;
          state_d    = S_TXG;
        end
      end
      // the UART core raises is_transmitting one cycle after the trigger
      S_TXG: state_d = S_TXW;
      S_TXW: begin
        if (!tx_busy) begin
          rsp_d   = {rsp_q[23:0], 8'h00};
          rn_d    = rn_q - 3'd1;
          state_d = (rn_q == 3'd1) ? S_IDLE : S_TXS;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rx_received && (state_q == S_BUS || state_q == S_TXS ||
                        state_q == S_TXG || state_q == S_TXW))
      ovr_d = 1'b1;
  end

  assign mem_valid = valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = (valid_q && wr_q) ? 4'hF : 4'h0;
  assign tx_byte   = rsp_q[31:24];
  assign busy      = (state_q != S_IDLE);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: UART and bus responder
// models, expected bus accesses and response bytes queued per frame.
module tb_uart_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_error = 1'b0;
  logic        tx_trigger;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  uart_bus_master #(
    .FRAME_TIMEOUT(100),
    .BUS_TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_received(rx_received),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .tx_trigger (tx_trigger),
    .tx_byte    (tx_byte),
    .tx_busy    (tx_busy),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .overrun    (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
  } bus_t;

  bus_t       busq[$];
  logic [7:0] txq[$];

  // bus responder: ready tied high, or after rdy_delay wait cycles
  logic rdy_tie   = 1'b0;
  int   rdy_delay = 0;
  int   vcnt      = 0;
  assign mem_ready = rdy_tie | (mem_valid && vcnt == rdy_delay);
  always @(posedge clk) vcnt <= mem_valid ? vcnt + 1 : 0;

  // UART core: busy rises one cycle after trigger, lasts 20 cycles
  logic pend = 1'b0;
  int   bcnt = 0;
  assign tx_busy = (bcnt != 0);
  always @(posedge clk) begin
    pend <= tx_trigger;
    if (pend) bcnt <= 20;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  logic prev_trig  = 1'b0;
  logic prev_valid = 1'b0;
  int   vlen       = 0;
  int   cur_len    = 0;

  always @(negedge clk) begin
    if (tx_trigger === 1'b1) begin
      check("trig_idle", tx_busy, 0);
      check("trig_1cyc", prev_trig, 0);
      if (txq.size() == 0) check("tx_unexp", txq.size(), 1);
      else check("tx_byte", tx_byte, txq.pop_front());
    end
    prev_trig <= tx_trigger;
    if (mem_valid === 1'b1 && prev_valid === 1'b0) begin
      if (busq.size() == 0) begin
        check("bus_unexp", busq.size(), 1);
        cur_len <= 0;
      end else begin
        check("bus_addr", mem_addr, busq[0].addr);
        check("bus_wstrb", mem_wstrb, busq[0].wstrb);
        if (busq[0].wstrb == 4'hF)
          check("bus_wdata", mem_wdata, busq[0].wdata);
        cur_len <= busq[0].len;
        void'(busq.pop_front());
      end
      vlen <= 1;
    end else if (mem_valid === 1'b1) begin
      vlen <= vlen + 1;
    end
    if (mem_valid === 1'b0 && prev_valid === 1'b1 && cur_len != 0)
      check("valid_len", vlen, cur_len);
    prev_valid <= mem_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte     = b;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int len);
    bus_t e;
    e.addr  = a;
    e.wdata = d;
    e.wstrb = s;
    e.len   = len;
    busq.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check(tag, busy, 0);
    repeat (30) @(negedge clk);
    check("txq_empty", txq.size(), 0);
    check("busq_empty", busq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", mem_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_trig", tx_trigger, 0);
    check("rst_txb", tx_byte, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("instr", mem_instr, 0);
    rst = 1'b0;

    // write, responder ready after 3 wait cycles
    rdy_delay = 3;
    push_bus(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 4);
    txq.push_back(8'h4B);
    foreach (txq[i]) ;
    send_byte(8'h57);
    send_byte(8'h40); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'hBE); send_byte(8'hEF);
    wait_idle("wr_idle");

    // read, zero-wait responder, unaligned address
    rdy_tie   = 1'b1;
    mem_rdata = 32'h1234_5678;
    push_bus(32'h0000_0004, 32'h0, 4'h0, 1);
    txq.push_back(8'h12); txq.push_back(8'h34);
    txq.push_back(8'h56); txq.push_back(8'h78);
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h07);
    wait_idle("rd_idle");
    rdy_tie = 1'b0;

    // unknown opcode, then a normal read
    txq.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle("unk_idle");
    rdy_delay = 0;
    mem_rdata = 32'hA5A5_5A5A;
    push_bus(32'h0000_0100, 32'h0, 4'h0, 1);
    txq.push_back(8'hA5); txq.push_back(8'hA5);
    txq.push_back(8'h5A); txq.push_back(8'h5A);
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    wait_idle("rd2_idle");

    // partial frame abandoned by the frame timeout
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    check("ftmo_busy", busy, 1);
    repeat (105) @(negedge clk);
    check("ftmo_idle", busy, 0);
    rdy_delay = 1;
    push_bus(32'h0000_0008, 32'h0102_0304, 4'hF, 2);
    txq.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h08);
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04);
    wait_idle("ftmo_wr_idle");

    // receive error mid-frame
    send_byte(8'h52); send_byte(8'h00);
    @(negedge clk);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    @(negedge clk);
    check("rxerr_idle", busy, 0);

    // bus timeout
    rdy_delay = 1000;
    push_bus(32'h0000_000C, 32'h0, 4'h0, 16);
    txq.push_back(8'h45);
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h0C);
    wait_idle("btmo_idle");

    // overrun during response transmit
    check("ovr_pre", overrun, 0);
    rdy_tie   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    push_bus(32'h0000_0010, 32'h0, 4'h0, 1);
    txq.push_back(8'hCA); txq.push_back(8'hFE);
    txq.push_back(8'hF0); txq.push_back(8'h0D);
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h10);
    for (int i = 0; i < 200 && !tx_busy; i++) @(negedge clk);
    check("ovr_txbusy", tx_busy, 1);
    send_byte(8'h99);
    check("ovr_set", overrun, 1);
    wait_idle("ovr_idle");
    check("ovr_sticky", overrun, 1);
    rdy_tie = 1'b0;

    // reset while the bus access is pending
    rdy_delay = 1000;
    push_bus(32'h0000_0020, 32'h0, 4'h0, 0);
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h20);
    for (int i = 0; i < 50 && !mem_valid; i++) @(negedge clk);
    check("rst_pre_valid", mem_valid, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", mem_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ovr", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("end_txq", txq.size(), 0);
    check("end_busq", busq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
